encode8to3_pending: RTL and testbench
=====================================

// Module: encode8to3_pending
// PURPOSE
//   Request-side counterpart to the 3:8 decode path. Captures one-hot or multi-hot
//   request pulses on 8 lines into a pending set. Presents each pending line, one at
//   a time, as a 3-bit code on a valid/ready output, and retires the line when the
//   code is accepted. Feeds the 3:8 decode path and interrupt/select logic at the far end.
// PARAMETERS
//   ROTATE  1  1 = round-robin selection starting after last issued code; 0 = fixed, lowest index first
// PORTS
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous reset, active low
//   in        in   8   request lines; bit i high for a cycle = one request for code i
//   enable    in   1   capture enable; when low, in is ignored (pending set keeps its contents)
//   out       out  3   binary code of the presented line; valid only while out_valid=1
//   out_valid out  1   out holds an issued code
//   out_ready in   1   consumer accepts out this cycle when out_valid&out_ready
//   pending   out  8   current pending set (registered)
//   count     out  4   popcount of pending, 0..8 (registered, same edge as pending)
//   overrun   out  1   one-cycle pulse: a request arrived on a line already pending
// BEHAVIOUR
//   Reset (rst_n=0 at an edge): pending=0, count=0, out=0, out_valid=0, overrun=0,
//     last=3'd7, so the first round-robin search starts at code 0. in is ignored.
//     Reset mid-transfer discards the presented code and all pending requests.
//   Capture: req = in & {8{enable}}. At each edge:
//     pending <= (pending & ~issue_mask) | req.
//     If a line is issued and re-requested at the same edge, the set wins and the line stays pending.
//   overrun <= |(req & pending & ~issue_mask). Merged requests count once. Not sticky.
//   Load condition: load = ~out_valid | out_ready. If load and pending!=0:
//     out <= sel, out_valid <= 1, last <= sel, issue_mask = onehot(sel).
//     If load and pending==0: out_valid <= 0, out holds its last value.
//   Selection is made from the registered pending only. Same-edge req is not eligible.
//     ROTATE=1: first set bit scanning last+1, last+2, ... modulo 8 (7 wraps to 0).
//     ROTATE=0: lowest set index.
//   Hold: while out_valid & ~out_ready, out and out_valid stay stable; pending keeps collecting.
//   Latency: request sampled at edge k -> pending at k -> out_valid/out at edge k+1,
//     if the output stage is free.
//   Throughput: one code per cycle with out_ready held high.
//   A presented code is no longer in pending. A new request on that line while it is
//     presented sets pending again and is not an overrun.
//   count is 4 bits. count = 8 when all lines are pending. There is no saturation case.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with in=8'hFF, enable=1 -> pending=0, out_valid=0, count=0, overrun=0.
//   2 Single request: in=8'h20 for 1 cycle, out_ready=1 -> out=3'd5, out_valid=1 one edge later
//     for 1 cycle; pending returns to 0.
//   3 Round-robin (ROTATE=1): in=8'h91 in 1 cycle, out_ready=1 -> out sequence 0,4,7.
//     Then re-request 8'h91 -> 0,4,7 again (last=7 wraps to 0).
//     With ROTATE=0 and 8'h01 re-requested each cycle, code 0 repeats and code 4 starves.
//   4 Backpressure: load 8'h0C, out_ready=0 for 5 cycles -> out=2 held stable, pending=8'h08, count=1.
//     Raise out_ready -> out 2 then 3.
//   5 Overrun/merge: pending bit 3 set, in=8'h08 again -> overrun=1 for 1 cycle, count unchanged.
//     Same request on the line currently presented -> overrun=0, pending bit set.
//   6 Enable and reset mid-op: in=8'hFF with enable=0 -> no change.
//     With 5 pending and out_valid=1, rst_n=0 for 1 cycle -> all cleared, next code after
//     new in=8'h80 is 7.

Source files
------------

// File: rtl/encode8to3_pending_if.sv
// Code handshake between the request encoder and its consumer.
// The master presents a 3-bit code under valid; the slave accepts with ready.
interface encode8to3_pending_if;
    logic [2:0] out;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/encode8to3_pending.sv
// Collects 8 request lines into a pending set and issues one 3-bit code per accepted transfer.
// Latency: request captured at edge k, presented at edge k+1 when the output stage is free.
// Backpressure: out/out_valid hold while out_ready is low; pending keeps accumulating requests.
module encode8to3_pending #(
    parameter bit ROTATE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in,
    input  logic                        enable,
    encode8to3_pending_if.master        code,
    output logic [7:0]                  pending,
    output logic [3:0]                  count,
    output logic                        overrun
);

    logic [2:0] out_q;
    logic       out_valid_q;
    logic [2:0] last_q;

    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic       load;
    logic       issue;
    logic [7:0] req;
    logic [7:0] issue_mask;
    logic [7:0] pending_nxt;
    logic [3:0] count_nxt;

    // Round-robin scan starts one past the last issued code, so last itself is checked last.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ROTATE) begin
                idx = last_q + 3'(i + 1);
            end else begin
                idx = 3'(i);
            end
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        req         = in & {8{enable}};
        load        = ~out_valid_q | code.out_ready;
        issue       = load & found;
        issue_mask  = issue ? (8'd1 << sel) : 8'd0;
        // A same-edge request on the issued line wins, so that line stays pending.
        pending_nxt = (pending & ~issue_mask) | req;
        count_nxt   = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_nxt = count_nxt + 4'(pending_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= 8'd0;
            count       <= 4'd0;
            overrun     <= 1'b0;
            out_q       <= 3'd0;
            out_valid_q <= 1'b0;
            last_q      <= 3'd7;
        end else begin
            pending <= pending_nxt;
            count   <= count_nxt;
            overrun <= |(req & pending & ~issue_mask);
            if (load) begin
                if (issue) begin
                    out_q       <= sel;
                    out_valid_q <= 1'b1;
                    last_q      <= sel;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign code.out       = out_q;
    assign code.out_valid = out_valid_q;

endmodule

// File: tb/tb_encode8to3_pending.sv
// Drives a round-robin and a fixed-priority encoder with shared stimulus and checks both.
module tb_encode8to3_pending;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic       enable;
    logic [7:0] pending0, pending1;
    logic [3:0] count0, count1;
    logic       overrun0, overrun1;

    int errors;
    int checks;

    encode8to3_pending_if cif0 ();
    encode8to3_pending_if cif1 ();

    encode8to3_pending #(.ROTATE(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in(in), .enable(enable), .code(cif0),
        .pending(pending0), .count(count0), .overrun(overrun0)
    );

    encode8to3_pending #(.ROTATE(1'b0)) dut_fix (
        .clk(clk), .rst_n(rst_n), .in(in), .enable(enable), .code(cif1),
        .pending(pending1), .count(count1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 is the round-robin encoder, index 1 the fixed-priority one.
    bit [7:0] m_pend [2];
    bit [2:0] m_out  [2];
    bit       m_vld  [2];
    bit [2:0] m_last [2];
    bit       m_ovr  [2];

    function automatic int pick(bit [7:0] p, bit [2:0] last, bit rot);
        int j;
        for (int k = 1; k <= 8; k++) begin
            j = rot ? (int'(last) + k) % 8 : k - 1;
            if (p[j]) return j;
        end
        return -1;
    endfunction

    // Advance one clock: compute the model's next state from current inputs, then commit after the edge.
    task automatic tick();
        bit [7:0] n_pend [2];
        bit [2:0] n_out  [2];
        bit       n_vld  [2];
        bit [2:0] n_last [2];
        bit       n_ovr  [2];
        for (int d = 0; d < 2; d++) begin
            bit [7:0] req;
            bit [7:0] mask;
            int       s;
            bit       rdy;
            rdy = (d == 0) ? cif0.out_ready : cif1.out_ready;
            n_pend[d] = m_pend[d];
            n_out[d]  = m_out[d];
            n_vld[d]  = m_vld[d];
            n_last[d] = m_last[d];
            n_ovr[d]  = m_ovr[d];
            if (!rst_n) begin
                n_pend[d] = 8'd0;
                n_out[d]  = 3'd0;
                n_vld[d]  = 1'b0;
                n_last[d] = 3'd7;
                n_ovr[d]  = 1'b0;
            end else begin
                req  = enable ? in : 8'd0;
                mask = 8'd0;
                if (!m_vld[d] || rdy) begin
                    s = pick(m_pend[d], m_last[d], d == 0);
                    if (s >= 0) begin
                        mask      = 8'd1 << s;
                        n_out[d]  = 3'(s);
                        n_last[d] = 3'(s);
                        n_vld[d]  = 1'b1;
                    end else begin
                        n_vld[d] = 1'b0;
                    end
                end
                n_pend[d] = (m_pend[d] & ~mask) | req;
                n_ovr[d]  = |(req & m_pend[d] & ~mask);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = n_pend[d];
            m_out[d]  = n_out[d];
            m_vld[d]  = n_vld[d];
            m_last[d] = n_last[d];
            m_ovr[d]  = n_ovr[d];
        end
    endtask

    task automatic set_ready(input logic r);
        cif0.out_ready = r;
        cif1.out_ready = r;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        in     = 8'hFF;
        enable = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        in    = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pending0 !== 8'h00 || cif0.out_valid !== 1'b0 || count0 !== 4'd0 || overrun0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_rr: pending=%h valid=%b count=%0d overrun=%b, want 00/0/0/0",
                     pending0, cif0.out_valid, count0, overrun0);
        end
        checks++;
        if (pending1 !== 8'h00 || cif1.out_valid !== 1'b0 || count1 !== 4'd0 || overrun1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_fix: pending=%h valid=%b count=%0d overrun=%b, want 00/0/0/0",
                     pending1, cif1.out_valid, count1, overrun1);
        end
    endtask

    task automatic test_single();
        set_ready(1'b1);
        in = 8'h20;
        tick();
        in = 8'h00;
        checks++;
        if (pending0 !== 8'h20 || cif0.out_valid !== 1'b0 || count0 !== 4'd1) begin
            errors++;
            $display("FAIL single_capture: pending=%h valid=%b count=%0d, want 20/0/1",
                     pending0, cif0.out_valid, count0);
        end
        tick();
        checks++;
        if (cif0.out_valid !== 1'b1 || cif0.out !== 3'd5 || pending0 !== 8'h00 || count0 !== 4'd0) begin
            errors++;
            $display("FAIL single_issue: valid=%b out=%0d pending=%h count=%0d, want 1/5/00/0",
                     cif0.out_valid, cif0.out, pending0, count0);
        end
        tick();
        checks++;
        if (cif0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: valid=%b, want 0", cif0.out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'd0;
        exp_seq[1] = 3'd4;
        exp_seq[2] = 3'd7;
        do_reset();
        set_ready(1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            in = 8'h91;
            tick();
            in = 8'h00;
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if (cif0.out_valid !== 1'b1 || cif0.out !== exp_seq[k]) begin
                    errors++;
                    $display("FAIL rr_seq pass%0d step%0d: valid=%b out=%0d, want 1/%0d",
                             pass, k, cif0.out_valid, cif0.out, exp_seq[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        bit rr_saw4;
        bit fix_saw4;
        rr_saw4  = 1'b0;
        fix_saw4 = 1'b0;
        do_reset();
        set_ready(1'b1);
        in = 8'h11;
        tick();
        in = 8'h01;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cif0.out_valid && cif0.out == 3'd4) rr_saw4 = 1'b1;
            if (cif1.out_valid && cif1.out == 3'd4) fix_saw4 = 1'b1;
            checks++;
            if (cif1.out_valid !== 1'b1 || cif1.out !== 3'd0 || pending1[4] !== 1'b1) begin
                errors++;
                $display("FAIL fixed_repeat%0d: valid=%b out=%0d pend4=%b, want 1/0/1",
                         k, cif1.out_valid, cif1.out, pending1[4]);
            end
        end
        in = 8'h00;
        checks++;
        if (rr_saw4 !== 1'b1 || fix_saw4 !== 1'b0) begin
            errors++;
            $display("FAIL starvation: rr_issued4=%b fixed_issued4=%b, want 1/0", rr_saw4, fix_saw4);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ready(1'b0);
        in = 8'h0C;
        tick();
        in = 8'h00;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (cif0.out_valid !== 1'b1 || cif0.out !== 3'd2 || pending0 !== 8'h08 || count0 !== 4'd1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b out=%0d pending=%h count=%0d, want 1/2/08/1",
                         k, cif0.out_valid, cif0.out, pending0, count0);
            end
        end
        set_ready(1'b1);
        tick();
        checks++;
        if (cif0.out_valid !== 1'b1 || cif0.out !== 3'd3 || pending0 !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: valid=%b out=%0d pending=%h, want 1/3/00",
                     cif0.out_valid, cif0.out, pending0);
        end
        tick();
        checks++;
        if (cif0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: valid=%b, want 0", cif0.out_valid);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        set_ready(1'b0);
        in = 8'h0C;
        tick();
        in = 8'h00;
        tick();
        in = 8'h08;
        tick();
        in = 8'h00;
        checks++;
        if (overrun0 !== 1'b1 || pending0 !== 8'h08 || count0 !== 4'd1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b pending=%h count=%0d, want 1/08/1",
                     overrun0, pending0, count0);
        end
        tick();
        checks++;
        if (overrun0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse: overrun=%b, want 0", overrun0);
        end
        in = 8'h04;
        tick();
        in = 8'h00;
        checks++;
        if (overrun0 !== 1'b0 || pending0 !== 8'h0C || count0 !== 4'd2 || cif0.out !== 3'd2) begin
            errors++;
            $display("FAIL presented_rerequest: overrun=%b pending=%h count=%0d out=%0d, want 0/0C/2/2",
                     overrun0, pending0, count0, cif0.out);
        end
    endtask

    task automatic test_enable_reset();
        enable = 1'b0;
        in     = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pending0 !== 8'h0C || cif0.out !== 3'd2 || cif0.out_valid !== 1'b1 || overrun0 !== 1'b0) begin
                errors++;
                $display("FAIL enable_low%0d: pending=%h out=%0d valid=%b overrun=%b, want 0C/2/1/0",
                         k, pending0, cif0.out, cif0.out_valid, overrun0);
            end
        end
        enable = 1'b1;
        in     = 8'h00;
        do_reset();
        set_ready(1'b0);
        in = 8'h3F;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (count0 !== 4'd5 || cif0.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d valid=%b, want 5/1", count0, cif0.out_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (pending0 !== 8'h00 || count0 !== 4'd0 || cif0.out_valid !== 1'b0 || cif0.out !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: pending=%h count=%0d valid=%b out=%0d, want 00/0/0/0",
                     pending0, count0, cif0.out_valid, cif0.out);
        end
        set_ready(1'b1);
        in = 8'h80;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (cif0.out_valid !== 1'b1 || cif0.out !== 3'd7 || cif1.out_valid !== 1'b1 || cif1.out !== 3'd7) begin
            errors++;
            $display("FAIL post_reset: rr=%b/%0d fixed=%b/%0d, want 1/7 on both",
                     cif0.out_valid, cif0.out, cif1.out_valid, cif1.out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in     = 8'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            cif0.out_ready = ($urandom_range(0, 2) != 0);
            cif1.out_ready = ($urandom_range(0, 2) != 0);
            if (($urandom_range(0, 6) == 0)) in = 8'h00;
            tick();
            checks++;
            if (cif0.out_valid !== m_vld[0] || cif0.out !== m_out[0] || pending0 !== m_pend[0] ||
                count0 !== 4'($countones(m_pend[0])) || overrun0 !== m_ovr[0]) begin
                errors++;
                $display("FAIL random_rr cyc%0d: out=%0d/%b pend=%h cnt=%0d ovr=%b, want %0d/%b %h %0d %b",
                         k, cif0.out, cif0.out_valid, pending0, count0, overrun0,
                         m_out[0], m_vld[0], m_pend[0], $countones(m_pend[0]), m_ovr[0]);
            end
            checks++;
            if (cif1.out_valid !== m_vld[1] || cif1.out !== m_out[1] || pending1 !== m_pend[1] ||
                count1 !== 4'($countones(m_pend[1])) || overrun1 !== m_ovr[1]) begin
                errors++;
                $display("FAIL random_fix cyc%0d: out=%0d/%b pend=%h cnt=%0d ovr=%b, want %0d/%b %h %0d %b",
                         k, cif1.out, cif1.out_valid, pending1, count1, overrun1,
                         m_out[1], m_vld[1], m_pend[1], $countones(m_pend[1]), m_ovr[1]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        in     = 8'h00;
        enable = 1'b1;
        set_ready(1'b0);
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 8'd0;
            m_out[d]  = 3'd0;
            m_vld[d]  = 1'b0;
            m_last[d] = 3'd7;
            m_ovr[d]  = 1'b0;
        end
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_backpressure();
        test_overrun();
        test_enable_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
